dmem_responder: RTL

- Data-memory responder: the target end of the core's load/store interface, driven by the ReadControl/WriteControl size codes.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a parameterised number of wait states, then performs the byte-lane masked write or the sign/zero-extended read.
- Returns the result over a response handshake and flags misaligned, out-of-range and illegal accesses.

---
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory target for the core load/store port: one request at a time,
// fixed wait states, byte-lane stores and sign/zero-extended loads.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic          is_b, is_h, is_w;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          mem_we;

  assign widx = addr_q[AW+1:2];

  always_comb begin
    is_b     = ctrl_q[1:0] == 2'b00;
    is_h     = ctrl_q[1:0] == 2'b01;
    is_w     = ctrl_q == 3'b010;
    acc_err  = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS))
             | (is_h & addr_q[0])
             | (is_w & (addr_q[1:0] != 2'b00))
             | ~(is_b | is_h | is_w)
             | (we_q & ctrl_q[2]);
    rd_word  = mem_q[widx];
    rd_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    be       = 4'b1111;
    wlane    = wdata_q;
    unique case (1'b1)
      is_b: begin
        load_val = {{24{~ctrl_q[2] & rd_byte[7]}}, rd_byte};
        be       = 4'b0001 << addr_q[1:0];
        wlane    = {4{wdata_q[7:0]}};
      end
      is_h: begin
        load_val = {{16{~ctrl_q[2] & rd_half[15]}}, rd_half};
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          ctrl_d  = req_ctrl;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        err_d   = acc_err;
        rdata_d = (acc_err | we_q) ? 32'd0 : load_val;
        mem_we  = ~acc_err & we_q & ~rst;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      ctrl_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule
